// File: rtl/sd_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// sd_fifo_wr_arb
//
// Packet-aware round-robin arbiter sharing the single write port of one
// sd_sync_fifo between N requesters. Arbitration only happens at packet
// boundaries. A granted requester keeps the FIFO write port until its last
// beat is accepted, or until its packet is cut short at MAX_PKT beats.
//
// Handshake: every port pair (req_valid[i]/req_ready[i], m_valid/m_ready)
// follows strict valid/ready semantics. A beat transfers on a rising clk_s
// edge where valid and ready are both high. A source that raised valid keeps
// valid, data and last stable until that transfer. Ready may depend
// combinationally on the other side, but valid never depends on ready.
//
// Ports
//   clk_s      in   1        clock; all logic is in this domain
//   rstn       in   1        synchronous active-low reset
//   req_valid  in   N        per-requester beat valid
//   req_data   in   N*WIDTH  per-requester data, requester i at [i*WIDTH +: WIDTH]
//   req_last   in   N        per-requester last-beat-of-packet flag
//   req_ready  out  N        per-requester accept, at most one bit high
//   m_valid    out  1        beat valid toward the FIFO (s_valid)
//   m_data     out  WIDTH    beat data (s_data)
//   m_id       out  IDW      id of the granted requester
//   m_last     out  1        end of packet, real or forced
//   m_ready    in   1        FIFO s_ready (~is_full)
//   busy       out  1        a grant is held
//   err_trunc  out  1        one-cycle pulse: a packet was forcibly truncated
//   err_id     out  IDW      id of the truncated requester, valid with err_trunc
//   dbg_state  out  1        current FSM state (0 = IDLE, 1 = LOCK)
// -----------------------------------------------------------------------------
module sd_fifo_wr_arb #(
    parameter int N       = 4,
    parameter int WIDTH   = 8,
    parameter int MAX_PKT = 16,
    parameter int IDW     = $clog2(N)
) (
    input  logic               clk_s,
    input  logic               rstn,
    input  logic [N-1:0]       req_valid,
    input  logic [N*WIDTH-1:0] req_data,
    input  logic [N-1:0]       req_last,
    output logic [N-1:0]       req_ready,
    output logic               m_valid,
    output logic [WIDTH-1:0]   m_data,
    output logic [IDW-1:0]     m_id,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy,
    output logic               err_trunc,
    output logic [IDW-1:0]     err_id,
    output logic               dbg_state
);

    localparam int CW = $clog2(MAX_PKT + 1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_LOCK = 1'b1;

    localparam logic [CW-1:0]  FORCE_CNT = CW'(MAX_PKT - 1);
    localparam logic [IDW-1:0] LAST_ID   = IDW'(N - 1);
    localparam logic [N-1:0]   ONE_HOT0  = {{(N-1){1'b0}}, 1'b1};

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic           state;
    logic [IDW-1:0] grant;
    logic [IDW-1:0] rr_ptr;
    logic [CW-1:0]  beat_cnt;

    // -------------------------------------------------------------------------
    // Round-robin pick: first requester with its bit set in vld, scanning
    // start, start+1, ... with wrap-around at N-1. The index is wrapped
    // explicitly so non-power-of-two N never scans a non-existent requester.
    // Returns {found, index}.
    // -------------------------------------------------------------------------
    function automatic logic [IDW:0] pick(input logic [N-1:0]   vld,
                                          input logic [IDW-1:0] start);
        logic [IDW:0]   res;
        logic [IDW-1:0] cur;
        res = '0;
        cur = start;
        for (int k = 0; k < N; k++) begin
            if (!res[IDW] && vld[cur]) begin
                res = {1'b1, cur};
            end
            cur = (cur == LAST_ID) ? '0 : cur + 1'b1;
        end
        return res;
    endfunction

    // -------------------------------------------------------------------------
    // Combinational datapath and decisions
    // -------------------------------------------------------------------------
    logic [WIDTH-1:0] data_arr [N];
    logic             is_lock;
    logic             force_last;
    logic             acc;
    logic [IDW-1:0]   grant_inc;
    logic [N-1:0]     other_valid;
    logic             idle_found;
    logic [IDW-1:0]   idle_pick;
    logic             next_found;
    logic [IDW-1:0]   next_pick;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        is_lock    = (state == ST_LOCK);
        force_last = is_lock && (beat_cnt == FORCE_CNT);
        grant_inc  = (grant == LAST_ID) ? '0 : grant + 1'b1;

        // Pass-through toward the FIFO; everything is quiet outside LOCK.
        m_valid   = is_lock & req_valid[grant];
        m_data    = is_lock ? data_arr[grant] : '0;
        m_id      = is_lock ? grant : '0;
        m_last    = is_lock & (req_last[grant] | force_last);
        req_ready = (is_lock && m_ready) ? (ONE_HOT0 << grant) : '0;

        acc = m_valid & m_ready;

        // The owner of the finishing packet is masked out of the
        // back-to-back pick, so it always yields for at least one cycle.
        other_valid = req_valid & ~(ONE_HOT0 << grant);

        {idle_found, idle_pick} = pick(req_valid, rr_ptr);
        {next_found, next_pick} = pick(other_valid, grant_inc);
    end

    assign busy      = is_lock;
    assign dbg_state = state;

    // -------------------------------------------------------------------------
    // FSM and counters
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_s) begin
        if (!rstn) begin
            state     <= ST_IDLE;
            grant     <= '0;
            rr_ptr    <= '0;
            beat_cnt  <= '0;
            err_trunc <= 1'b0;
            err_id    <= '0;
        end else begin
            err_trunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (idle_found) begin
                        grant <= idle_pick;
                        state <= ST_LOCK;
                    end
                end
                ST_LOCK: begin
                    // The grant only moves at an accepted end of packet;
                    // valid drops or new requests never disturb it.
                    if (acc) begin
                        if (m_last) begin
                            beat_cnt <= '0;
                            rr_ptr   <= grant_inc;
                            if (force_last && !req_last[grant]) begin
                                err_trunc <= 1'b1;
                                err_id    <= grant;
                            end
                            if (next_found) begin
                                grant <= next_pick;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_fifo_wr_arb.sv
// -----------------------------------------------------------------------------
// tb_sd_fifo_wr_arb
//
// Bench for sd_fifo_wr_arb (N=4, WIDTH=8, MAX_PKT=4). Each requester streams
// beats from its own source queue. Every beat queued is also turned into an
// expected entry {trunc, last, data} in that requester's expected queue,
// where the packet is split into MAX_PKT-beat segments. A monitor pops the
// queue named by m_id on every accepted beat. Directed sequences check
// timing, and a randomized phase checks the beat stream.
// -----------------------------------------------------------------------------
module tb_sd_fifo_wr_arb;

  localparam int N       = 4;
  localparam int W       = 8;
  localparam int MAX_PKT = 4;
  localparam int IDW     = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk_s = 1'b0;
  logic rstn;
  always #5 clk_s = ~clk_s;

  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_last;
  logic [N-1:0]   req_ready;
  logic           m_valid;
  logic [W-1:0]   m_data;
  logic [IDW-1:0] m_id;
  logic           m_last;
  logic           m_ready;
  logic           busy;
  logic           err_trunc;
  logic [IDW-1:0] err_id;
  logic           dbg_state;

  sd_fifo_wr_arb #(.N(N), .WIDTH(W), .MAX_PKT(MAX_PKT)) dut (
    .clk_s     (clk_s),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_id      (m_id),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .busy      (busy),
    .err_trunc (err_trunc),
    .err_id    (err_id),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [7:0]   gap;
    logic         last;
    logic [W-1:0] data;
  } src_t;

  src_t         src_q [N][$];
  logic [W+1:0] exp_q [N][$];
  int           seg_pos [N];
  int           n_checks = 0;
  int           n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Reference rule: a packet is cut into segments of at most MAX_PKT beats;
  // a segment ends at a real last or at its MAX_PKT-th beat, and the latter
  // without a real last is a truncation.
  task automatic push_exp(input int id, input logic [W-1:0] data, input logic last);
    logic f;
    f = (seg_pos[id] == MAX_PKT - 1);
    exp_q[id].push_back({f & ~last, last | f, data});
    seg_pos[id] = (last || f) ? 0 : seg_pos[id] + 1;
  endtask

  task automatic send_beat(input int id, input logic [W-1:0] data, input logic last, input int gap);
    src_t s;
    s.gap  = 8'(gap);
    s.last = last;
    s.data = data;
    src_q[id].push_back(s);
    push_exp(id, data, last);
  endtask

  task automatic send_pkt(input int id, input int len, input int gap0);
    for (int b = 0; b < len; b++) begin
      send_beat(id, {2'(id), 6'($urandom)}, b == len - 1, (b == 0) ? gap0 : $urandom_range(0, 1));
    end
  endtask

  // After a reset the arbiter restarts its segment count, so the expectation
  // for whatever the requesters still hold is rebuilt from scratch.
  task automatic rebuild_exp();
    for (int i = 0; i < N; i++) begin
      exp_q[i].delete();
      seg_pos[i] = 0;
      for (int k = 0; k < src_q[i].size(); k++) begin
        push_exp(i, src_q[i][k].data, src_q[i][k].last);
      end
    end
  endtask

  function automatic int pending();
    int s;
    s = 0;
    for (int i = 0; i < N; i++) s += exp_q[i].size();
    return s;
  endfunction

  // ---------------------------------------------------------------------------
  // Requester drivers: present the head beat (after its gap) and hold it
  // until accepted.
  // ---------------------------------------------------------------------------
  initial begin : requesters
    logic [N-1:0] took;
    logic [N-1:0] loaded;
    int           gap_left [N];
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    took      = '0;
    loaded    = '0;
    for (int i = 0; i < N; i++) gap_left[i] = 0;
    forever begin
      @(posedge clk_s); #1;
      for (int i = 0; i < N; i++) begin
        if (took[i]) begin
          void'(src_q[i].pop_front());
          loaded[i] = 1'b0;
        end
        if (src_q[i].size() == 0) begin
          req_valid[i] = 1'b0;
        end else begin
          if (!loaded[i]) begin
            gap_left[i] = int'(src_q[i][0].gap);
            loaded[i]   = 1'b1;
          end
          if (gap_left[i] > 0) begin
            req_valid[i] = 1'b0;
            gap_left[i]--;
          end else begin
            req_valid[i]          = 1'b1;
            req_data[i*W +: W]    = src_q[i][0].data;
            req_last[i]           = src_q[i][0].last;
          end
        end
      end
      @(negedge clk_s);
      took = req_valid & req_ready;
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard monitor
  // ---------------------------------------------------------------------------
  initial begin : monitor
    logic [W+1:0]   e;
    logic           in_pkt;
    logic [IDW-1:0] pkt_id;
    logic           pend_trunc;
    logic [IDW-1:0] pend_id;
    in_pkt     = 1'b0;
    pkt_id     = '0;
    pend_trunc = 1'b0;
    pend_id    = '0;
    forever begin
      @(negedge clk_s);
      if (rstn) begin
        chk("err_trunc", err_trunc, pend_trunc);
        if (pend_trunc) chk("err_id", err_id, pend_id);
        chk("ready_onehot", ($countones(req_ready) <= 1), 1);
        if (!busy) chk("idle_m_valid", m_valid, 0);
        if (busy) chk("req_ready_map", req_ready, m_ready ? (4'b0001 << m_id) : 4'b0000);
      end
      pend_trunc = 1'b0;
      if (m_valid && m_ready) begin
        if (in_pkt) chk("grant_hold", m_id, pkt_id);
        n_checks++;
        if (exp_q[m_id].size() == 0) begin
          n_err++;
          $display("FAIL unexpected_beat: id %0d data %0h, expected no beat", m_id, m_data);
        end else begin
          e = exp_q[m_id].pop_front();
          chk("beat_data", m_data, e[W-1:0]);
          chk("beat_last", m_last, e[W]);
          pend_trunc = e[W+1];
          pend_id    = m_id;
        end
        in_pkt = !m_last;
        pkt_id = m_id;
      end
      if (!rstn) begin
        in_pkt     = 1'b0;
        pend_trunc = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  task automatic step();
    @(posedge clk_s); #2;
  endtask

  task automatic mid();
    @(negedge clk_s);
  endtask

  task automatic cyc();
    step();
    mid();
  endtask

  task automatic do_reset(input int n);
    step();
    rstn = 1'b0;
    repeat (n) begin
      mid();
      step();
    end
    rebuild_exp();
    rstn = 1'b1;
  endtask

  task automatic finish_run();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  endtask

  initial begin : watchdog
    #300000;
    n_checks++;
    n_err++;
    $display("FAIL watchdog: simulation still running at %0t, limit 300000", $time);
    finish_run();
  end

  initial begin : main
    int wait_cnt;
    rstn    = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < N; i++) seg_pos[i] = 0;

    // Reset and idle
    repeat (3) begin
      mid();
      chk("rst_m_valid", m_valid, 0);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_m_last", m_last, 0);
      chk("rst_err_trunc", err_trunc, 0);
      chk("rst_err_id", err_id, 0);
      chk("rst_m_id", m_id, 0);
      chk("rst_state", dbg_state, 0);
    end
    step();
    rstn = 1'b1;
    repeat (10) begin
      mid();
      chk("idle_busy", busy, 0);
      chk("idle_m_valid_out", m_valid, 0);
      step();
    end

    // Single packet from requester 1
    mid();
    send_beat(1, 8'hA1, 1'b0, 0);
    send_beat(1, 8'hA2, 1'b0, 0);
    send_beat(1, 8'hA3, 1'b1, 0);
    cyc();
    chk("sp_c0_m_valid", m_valid, 0);
    chk("sp_c0_busy", busy, 0);
    for (int k = 1; k <= 3; k++) begin
      cyc();
      chk("sp_m_valid", m_valid, 1);
      chk("sp_m_id", m_id, 1);
      chk("sp_m_data", m_data, 8'hA0 + 8'(k));
      chk("sp_m_last", m_last, (k == 3));
      chk("sp_state", dbg_state, 1);
    end
    cyc();
    chk("sp_c4_busy", busy, 0);

    // Round-robin with wrap
    do_reset(3);
    mid();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < N; i++) send_beat(i, 8'(16 * i + r), 1'b1, 0);
    end
    cyc();
    chk("rr_c0_m_valid", m_valid, 0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk("rr_m_valid", m_valid, 1);
      chk("rr_m_id", m_id, (k - 1) % N);
    end
    cyc();
    chk("rr_end_busy", busy, 0);

    // Backpressure
    do_reset(3);
    mid();
    for (int b = 0; b < 4; b++) send_beat(0, 8'hB0 + 8'(b), b == 3, 0);
    cyc();
    cyc();
    chk("bp_c1_data", m_data, 8'hB0);
    cyc();
    chk("bp_c2_data", m_data, 8'hB1);
    send_beat(3, 8'hD3, 1'b1, 0);
    for (int k = 3; k <= 7; k++) begin
      step();
      m_ready = 1'b0;
      mid();
      chk("bp_hold_valid", m_valid, 1);
      chk("bp_hold_ready", req_ready, 0);
      chk("bp_hold_data", m_data, 8'hB2);
      chk("bp_hold_id", m_id, 0);
    end
    step();
    m_ready = 1'b1;
    mid();
    chk("bp_resume_data", m_data, 8'hB2);
    chk("bp_resume_ready", req_ready, 4'b0001);
    cyc();
    chk("bp_last_data", m_data, 8'hB3);
    chk("bp_last_flag", m_last, 1);
    cyc();
    chk("bp_next_id", m_id, 3);
    chk("bp_next_valid", m_valid, 1);

    // Truncation
    do_reset(3);
    mid();
    for (int b = 0; b < 6; b++) send_beat(2, 8'hC0 + 8'(b), 1'b0, 0);
    cyc();
    for (int k = 1; k <= 4; k++) begin
      cyc();
      chk("tr_m_id", m_id, 2);
      chk("tr_m_data", m_data, 8'hC0 + 8'(k - 1));
      chk("tr_m_last", m_last, (k == 4));
    end
    cyc();
    chk("tr_err_trunc", err_trunc, 1);
    chk("tr_err_id", err_id, 2);
    chk("tr_bubble", m_valid, 0);
    cyc();
    chk("tr_err_clear", err_trunc, 0);
    chk("tr_rest_data", m_data, 8'hC4);
    chk("tr_rest_last", m_last, 0);
    cyc();
    chk("tr_rest2_data", m_data, 8'hC5);
    chk("tr_rest2_last", m_last, 0);
    cyc();
    chk("tr_hold_busy", busy, 1);
    chk("tr_hold_valid", m_valid, 0);

    // Reset mid-packet
    do_reset(3);
    mid();
    for (int b = 0; b < 5; b++) send_beat(1, 8'hE0 + 8'(b), b == 4, 0);
    cyc();
    cyc();
    chk("rm_c1_id", m_id, 1);
    step();
    rstn = 1'b0;
    mid();
    chk("rm_c2_valid", m_valid, 1);
    step();
    rebuild_exp();
    mid();
    chk("rm_c3_valid", m_valid, 0);
    chk("rm_c3_busy", busy, 0);
    chk("rm_c3_ready", req_ready, 0);
    send_beat(0, 8'h5A, 1'b1, 0);
    cyc();
    step();
    rstn = 1'b1;
    mid();
    chk("rm_c5_valid", m_valid, 0);
    cyc();
    chk("rm_first_id", m_id, 0);
    chk("rm_first_valid", m_valid, 1);
    cyc();
    chk("rm_second_id", m_id, 1);

    // Randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      step();
      m_ready = ($urandom_range(0, 3) != 0);
      mid();
      for (int i = 0; i < N; i++) begin
        if (src_q[i].size() < 3 && $urandom_range(0, 7) == 0) begin
          send_pkt(i, $urandom_range(1, 6), $urandom_range(0, 3));
        end
      end
    end
    step();
    m_ready  = 1'b1;
    wait_cnt = 0;
    while (pending() != 0 && wait_cnt < 400) begin
      cyc();
      wait_cnt++;
    end
    chk("drain_left", pending(), 0);
    cyc();
    cyc();
    chk("drain_busy", busy, 0);

    finish_run();
  end

endmodule

// File: doc/sd_fifo_wr_arb.md
# sd_fifo_wr_arb

Packet-aware round-robin arbiter that shares the single write port of one `sd_sync_fifo` between N requesters in the `clk_s` domain. Arbitration happens at packet boundaries only. Once granted, a requester owns the FIFO write port until its last beat is accepted, or until a forced truncation at `MAX_PKT` beats. The `m_*` side connects directly to the FIFO `s_valid`/`s_data`/`s_ready`. The integrator packs `m_id`/`m_last` into the FIFO word when needed.

## Interface
- `N`, default 4: number of requesters, must be ≥2.
- `WIDTH`, default 8: data width per beat.
- `MAX_PKT`, default 16: maximum beats per packet, must be ≥2; the beat counter is `$clog2(MAX_PKT+1)` bits.
- `IDW`, derived as `$clog2(N)`: requester-id width.
- `clk_s`  in  1  source-side clock; all logic is in this domain.
- `rstn`  in  1  reset, synchronous, active-low.
- `req_valid`  in  N  per-requester beat valid.
- `req_data`  in  N*WIDTH  per-requester data; requester i occupies bits `[i*WIDTH +: WIDTH]`.
- `req_last`  in  N  per-requester last-beat-of-packet flag.
- `req_ready`  out  N  per-requester accept; at most one bit is high at any time.
- `m_valid`  out  1  beat valid toward the FIFO.
- `m_data`  out  WIDTH  beat data.
- `m_id`  out  IDW  id of the granted requester.
- `m_last`  out  1  end of packet, either real or forced.
- `m_ready`  in  1  FIFO `s_ready`, i.e. `~is_full`.
- `busy`  out  1  a grant is held (state LOCK).
- `err_trunc`  out  1  one-cycle registered pulse signalling that a packet was forcibly truncated.
- `err_id`  out  IDW  id of the truncated requester; valid while `err_trunc` is high.

## Operation
- **State machine:** two states, IDLE and LOCK. Registers are `state`, `grant[IDW]`, `rr_ptr[IDW]`, `beat_cnt`, `err_trunc`, `err_id`.
- **Beat accept:** `acc = m_valid & m_ready`.
- **Pick function:** selects the first i with `req_valid[i]`, scanning `rr_ptr`, `rr_ptr+1`, … modulo N with wrap-around.
- **IDLE:**
  - `m_valid=0`, `req_ready=0`.
  - If any `req_valid` is high: `grant <= pick(rr_ptr)` and `state <= LOCK`.
  - Otherwise stay in IDLE.
- **LOCK, datapath:**
  - `m_valid = req_valid[grant]`, `m_data = req_data[grant]`, `m_id = grant`.
  - `req_ready[grant] = m_ready`; all other `req_ready` bits are 0.
- **Forced last:** `force = (beat_cnt == MAX_PKT-1)`.
- **m_last in LOCK:** `m_last = req_last[grant] | force`.
- **acc & !m_last:** `beat_cnt <= beat_cnt+1`.
- **acc & m_last, end of packet:**
  - `beat_cnt <= 0`.
  - `rr_ptr <= grant+1`, wrapping N-1 → 0 (explicit wrap for non-power-of-2 N).
  - Back-to-back re-arbitration uses pick starting at `grant+1`, over the current `req_valid` with bit `grant` masked:
    - If pick finds a requester: `grant <=` that requester and stay in LOCK.
    - If no other requester is valid: go to IDLE. The just-finished requester therefore always waits at least one cycle.
- **Truncation:** if `force & !req_last[grant] & acc`, then next cycle `err_trunc=1` and `err_id=grant`. Any remaining beats from that requester form a new packet at a later grant.
- **Grant stability:** `grant` never changes in LOCK except on `acc & m_last`, regardless of `req_valid` drops or new higher-priority requests.
- **Requester obligation:** keep valid/data/last stable from assertion until `req_ready`. The arbiter does not check this.

## Timing
- **Reset values:** `state=IDLE`, `grant=0`, `rr_ptr=0`, `beat_cnt=0`, `err_trunc=0`, `err_id=0`. Consequently `m_valid=0`, `req_ready=0`, `busy=0`, `m_last=0`.
- **Reset mid-packet:** the grant is dropped immediately on the next edge. The partial packet stays in the FIFO; recovery is upstream's responsibility.
- **Latency:** `req_valid` seen in IDLE at cycle t gives `m_valid` at t+1, one bubble.
- **Back-to-back:** after the last beat is accepted at t, the next requester's first beat can be accepted at t+1, with no bubble.
- **Pass-through paths:** `req_*`→`m_*` and `m_ready`→`req_ready` are combinational, zero latency.
- **Unchecked conditions:** `m_ready` low during IDLE has no effect; `m_ready=1` with `m_valid=0` is not an accept.
- **Sustained throughput:** 1 beat/cycle within a packet when `m_ready=1`.

## Test plan
- **Reset and idle:** hold `rstn=0` for 3 cycles, with `req_valid=0` after release → all outputs 0 during and after reset; `busy` stays 0 for 10 cycles.
- **Single packet:** requester 1 sends 0xA1, 0xA2, 0xA3 with `last` on 0xA3, `m_ready=1`, `req_valid` high at cycle 0 → beats at cycles 1–3 with `m_id=1`; `m_last` only at cycle 3; `busy` falls at cycle 4.
- **Round-robin with wrap:** N=4, all requesters continuously send 1-beat packets → grant order 0,1,2,3,0,1 with one beat per cycle from cycle 1 and no bubbles.
- **Backpressure:** `m_ready=0` for 5 cycles after beat 2 of requester 0's 4-beat packet, while requester 3 asserts valid → `req_ready=0` and `m_data` held; `grant` stays 0; beat 3 is accepted the cycle `m_ready` returns.
- **Truncation:** `MAX_PKT=4`, requester 2 sends 6 beats without `last`, requester 0 is idle → the 4th beat has `m_last=1`; `err_trunc=1` and `err_id=2` the next cycle for one cycle; the remaining 2 beats arrive after a one-cycle IDLE bubble with `beat_cnt` restarted.
- **Reset mid-packet:** assert `rstn=0` on beat 2 of 5 → next cycle `m_valid=0`, `rr_ptr=0`; after release, requester 0 wins first.
